// File: rtl/sample_rgb_pwm_if.sv
// Duty-triple handshake between a colour source and the RGB PWM block.
// The source holds duty_valid and the triple stable until it sees duty_ready.
interface sample_rgb_pwm_if;
   logic       duty_valid;
   logic       duty_ready;
   logic [7:0] duty_red;
   logic [7:0] duty_green;
   logic [7:0] duty_blue;

   modport master (
      output duty_valid, duty_red, duty_green, duty_blue,
      input  duty_ready
   );

   modport slave (
      input  duty_valid, duty_red, duty_green, duty_blue,
      output duty_ready
   );
endinterface

// File: rtl/sample_rgb_pwm.sv
// Three-channel 8-bit PWM LED driver with a one-deep duty buffer applied at period boundaries.
// Pins lag pwm_cnt/enable by 1 clock; duty_ready drops while a triple is pending and returns after the next boundary.
module sample_rgb_pwm #(
   parameter int unsigned PRESCALE = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   sample_rgb_pwm_if.slave  duty_if,
   output logic             period_start,
   output logic             led_red_n,
   output logic             led_green_n,
   output logic             led_blue_n
);

   localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

   logic [PW-1:0]   presc_cnt_q, presc_cnt_d;
   logic [7:0]      pwm_cnt_q, pwm_cnt_d;
   logic [2:0][7:0] act_q, act_d;
   logic [2:0][7:0] pend_q, pend_d;
   logic            pend_full_q, pend_full_d;
   logic            period_start_q, period_start_d;
   logic [2:0]      led_n_q, led_n_d;

   logic            tick;
   logic            boundary;
   logic            xfer;
   logic [2:0]      chan_on;

   always_comb begin
      tick     = (presc_cnt_q == PRESC_MAX);
      boundary = tick && (pwm_cnt_q == 8'hFF);
      xfer     = duty_if.duty_valid && !pend_full_q;

      presc_cnt_d = tick ? '0 : presc_cnt_q + PW'(1);
      pwm_cnt_d   = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;

      // Transfer needs an empty buffer and load needs a full one, so the two never collide;
      // a transfer on a boundary cycle therefore only fills pending.
      pend_d      = pend_q;
      pend_full_d = pend_full_q;
      act_d       = act_q;
      if (boundary && pend_full_q) begin
         act_d       = pend_q;
         pend_full_d = 1'b0;
      end
      if (xfer) begin
         pend_d      = {duty_if.duty_blue, duty_if.duty_green, duty_if.duty_red};
         pend_full_d = 1'b1;
      end

      for (int i = 0; i < 3; i++) begin
         chan_on[i] = enable && (pwm_cnt_q < act_q[i]);
      end
      led_n_d        = ~chan_on;
      period_start_d = boundary;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         presc_cnt_q    <= '0;
         pwm_cnt_q      <= '0;
         act_q          <= '0;
         pend_q         <= '0;
         pend_full_q    <= 1'b0;
         period_start_q <= 1'b0;
         led_n_q        <= '1;
      end else begin
         presc_cnt_q    <= presc_cnt_d;
         pwm_cnt_q      <= pwm_cnt_d;
         act_q          <= act_d;
         pend_q         <= pend_d;
         pend_full_q    <= pend_full_d;
         period_start_q <= period_start_d;
         led_n_q        <= led_n_d;
      end
   end

   assign duty_if.duty_ready = ~pend_full_q;
   assign period_start       = period_start_q;
   assign led_red_n          = led_n_q[0];
   assign led_green_n        = led_n_q[1];
   assign led_blue_n         = led_n_q[2];

endmodule

// File: tb/tb_sample_rgb_pwm.sv
// Directed bench for sample_rgb_pwm: one instance at PRESCALE=1, one at PRESCALE=3.
module tb_sample_rgb_pwm;

   logic clk = 1'b0;
   logic rst1, rst3, en1, en3;
   logic ps1, lr1, lg1, lb1;
   logic ps3, lr3, lg3, lb3;

   sample_rgb_pwm_if if1();
   sample_rgb_pwm_if if3();

   sample_rgb_pwm #(.PRESCALE(1)) u1 (
      .clock(clk), .reset(rst1), .enable(en1), .duty_if(if1.slave),
      .period_start(ps1), .led_red_n(lr1), .led_green_n(lg1), .led_blue_n(lb1)
   );

   sample_rgb_pwm #(.PRESCALE(3)) u3 (
      .clock(clk), .reset(rst3), .enable(en3), .duty_if(if3.slave),
      .period_start(ps3), .led_red_n(lr3), .led_green_n(lg3), .led_blue_n(lb3)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1);
   end

   typedef struct {
      logic [7:0] r, g, b;
      int         er, eg, eb;
   } vec_t;

   vec_t vecs[5];
   int tests = 0;
   int fails = 0;

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic write1(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
      int n = 0;
      if1.duty_red = r; if1.duty_green = g; if1.duty_blue = b;
      if1.duty_valid = 1'b1;
      while (!if1.duty_ready && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 2000) chk("write1_timeout", n, 0);
      @(negedge clk);
      if1.duty_valid = 1'b0;
   endtask

   task automatic wait_load1(input string nm);
      int n = 0;
      while (!if1.duty_ready && n < 1000) begin
         @(negedge clk);
         n++;
      end
      chk({nm, "_load_in_time"}, int'(n < 1000), 1);
      chk({nm, "_ps_at_load"}, int'(ps1), 1);
   endtask

   // Starts on a period_start cycle and ends on the next one.
   task automatic measure1(input bit drop, output int cr, output int cg, output int cb);
      cr = 0; cg = 0; cb = 0;
      for (int i = 0; i < 256; i++) begin
         if (!lr1) cr++;
         if (!lg1) cg++;
         if (!lb1) cb++;
         @(negedge clk);
         if (drop && i == 0) if1.duty_valid = 1'b0;
      end
   endtask

   initial begin
      int cr, cg, cb, lows, pulses, last, k, n;

      vecs[0] = '{r: 8'd64,  g: 8'd128, b: 8'd0,   er: 64,  eg: 128, eb: 0};
      vecs[1] = '{r: 8'd255, g: 8'd0,   b: 8'd255, er: 255, eg: 0,   eb: 255};
      vecs[2] = '{r: 8'd0,   g: 8'd0,   b: 8'd0,   er: 0,   eg: 0,   eb: 0};
      vecs[3] = '{r: 8'd1,   g: 8'd254, b: 8'd128, er: 1,   eg: 254, eb: 128};
      vecs[4] = '{r: 8'd200, g: 8'd17,  b: 8'd3,   er: 200, eg: 17,  eb: 3};

      rst1 = 1'b1; rst3 = 1'b1; en1 = 1'b1; en3 = 1'b1;
      if1.duty_valid = 1'b0; if1.duty_red = '0; if1.duty_green = '0; if1.duty_blue = '0;
      if3.duty_valid = 1'b0; if3.duty_red = '0; if3.duty_green = '0; if3.duty_blue = '0;

      repeat (3) @(negedge clk);
      chk("inrst_led_r", lr1, 1);
      chk("inrst_ps", ps1, 0);
      chk("inrst_ready", if1.duty_ready, 1);
      rst1 = 1'b0; rst3 = 1'b0;
      chk("rst_led_r", lr1, 1);
      chk("rst_led_g", lg1, 1);
      chk("rst_led_b", lb1, 1);
      chk("rst_ready", if1.duty_ready, 1);
      chk("rst3_led_r", lr3, 1);

      // Idle after reset: dark LEDs, pulse every 256 cycles
      lows = 0; pulses = 0; last = 0;
      for (int j = 1; j <= 1024; j++) begin
         @(negedge clk);
         lows += int'(!lr1) + int'(!lg1) + int'(!lb1);
         if (ps1) begin
            pulses++;
            chk("ps_spacing", j - last, 256);
            last = j;
         end
      end
      chk("idle_lows", lows, 0);
      chk("idle_pulses", pulses, 4);

      for (int v = 0; v < 5; v++) begin
         write1(vecs[v].r, vecs[v].g, vecs[v].b);
         wait_load1($sformatf("vec%0d", v));
         measure1(1'b0, cr, cg, cb);
         chk($sformatf("vec%0d_red", v), cr, vecs[v].er);
         chk($sformatf("vec%0d_green", v), cg, vecs[v].eg);
         chk($sformatf("vec%0d_blue", v), cb, vecs[v].eb);
      end

      // Second triple held against a full buffer
      write1(8'd255, 8'd0, 8'd255);
      if1.duty_red = 8'd1; if1.duty_green = 8'd1; if1.duty_blue = 8'd1;
      if1.duty_valid = 1'b1;
      chk("held_ready_low", if1.duty_ready, 0);
      n = 0;
      while (!if1.duty_ready && n < 1000) begin
         @(negedge clk);
         n++;
      end
      chk("held_load_in_time", int'(n < 1000), 1);
      chk("held_ps_at_load", ps1, 1);
      measure1(1'b1, cr, cg, cb);
      chk("seq1_red", cr, 255);
      chk("seq1_green", cg, 0);
      chk("seq1_blue", cb, 255);
      wait_load1("seq2");
      measure1(1'b0, cr, cg, cb);
      chk("seq2_red", cr, 1);
      chk("seq2_green", cg, 1);
      chk("seq2_blue", cb, 1);

      // Transfer on the boundary cycle itself
      repeat (255) @(negedge clk);
      if1.duty_red = 8'd100; if1.duty_green = 8'd150; if1.duty_blue = 8'd200;
      if1.duty_valid = 1'b1;
      chk("bnd_ready_before", if1.duty_ready, 1);
      @(negedge clk);
      if1.duty_valid = 1'b0;
      chk("bnd_ps", ps1, 1);
      chk("bnd_ready_after", if1.duty_ready, 0);
      measure1(1'b0, cr, cg, cb);
      chk("bnd_old_red", cr, 1);
      chk("bnd_old_blue", cb, 1);
      wait_load1("bnd_next");
      measure1(1'b0, cr, cg, cb);
      chk("bnd_new_red", cr, 100);
      chk("bnd_new_green", cg, 150);
      chk("bnd_new_blue", cb, 200);

      // Enable toggled mid-period
      write1(8'd200, 8'd50, 8'd100);
      wait_load1("en");
      repeat (50) @(negedge clk);
      en1 = 1'b0;
      @(negedge clk);
      chk("dis_red", lr1, 1);
      chk("dis_green", lg1, 1);
      chk("dis_blue", lb1, 1);
      repeat (29) @(negedge clk);
      chk("dis_red_held", lr1, 1);
      en1 = 1'b1;
      @(negedge clk);
      chk("reen_red", lr1, 0);
      chk("reen_green", lg1, 1);
      chk("reen_blue", lb1, 0);
      repeat (175) @(negedge clk);
      chk("reen_phase_ps", ps1, 1);
      measure1(1'b0, cr, cg, cb);
      chk("reen_red_cnt", cr, 200);
      chk("reen_green_cnt", cg, 50);
      chk("reen_blue_cnt", cb, 100);

      // Reset mid-period with a pending triple and a transfer on the reset cycles
      repeat (100) @(negedge clk);
      write1(8'd9, 8'd9, 8'd9);
      if1.duty_red = 8'd7; if1.duty_green = 8'd7; if1.duty_blue = 8'd7;
      if1.duty_valid = 1'b1;
      rst1 = 1'b1;
      repeat (2) @(negedge clk);
      rst1 = 1'b0;
      if1.duty_valid = 1'b0;
      chk("mrst_led_r", lr1, 1);
      chk("mrst_led_g", lg1, 1);
      chk("mrst_led_b", lb1, 1);
      chk("mrst_ps", ps1, 0);
      chk("mrst_ready", if1.duty_ready, 1);
      k = 0; lows = 0;
      do begin
         @(negedge clk);
         k++;
         lows += int'(!lr1) + int'(!lg1) + int'(!lb1);
      end while (!ps1 && k < 600);
      chk("mrst_first_bnd", k, 256);
      chk("mrst_dark", lows, 0);
      measure1(1'b0, cr, cg, cb);
      chk("mrst_red_cnt", cr, 0);
      chk("mrst_green_cnt", cg, 0);
      chk("mrst_blue_cnt", cb, 0);

      // PRESCALE=3 instance
      if3.duty_red = 8'd2; if3.duty_green = 8'd0; if3.duty_blue = 8'd0;
      if3.duty_valid = 1'b1;
      n = 0;
      while (!if3.duty_ready && n < 2000) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      if3.duty_valid = 1'b0;
      n = 0;
      while (!if3.duty_ready && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("p3_load_in_time", int'(n < 2000), 1);
      chk("p3_ps_at_load", ps3, 1);
      cr = 0; cg = 0; cb = 0;
      for (int i = 0; i < 768; i++) begin
         if (!lr3) cr++;
         if (!lg3) cg++;
         if (!lb3) cb++;
         @(negedge clk);
      end
      chk("p3_red_cnt", cr, 6);
      chk("p3_green_cnt", cg, 0);
      chk("p3_blue_cnt", cb, 0);
      chk("p3_period_ps", ps3, 1);
      repeat (2) @(negedge clk);
      chk("p3_lit_before_rst", lr3, 0);
      rst3 = 1'b1;
      @(negedge clk);
      chk("p3_rst_led_r", lr3, 1);
      @(negedge clk);
      rst3 = 1'b0;
      chk("p3_rst_ready", if3.duty_ready, 1);
      chk("p3_rst_ps", ps3, 0);
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!ps3 && k < 2000);
      chk("p3_first_bnd", k, 768);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/sample_rgb_pwm.md
SAMPLE_RGB_PWM -- requirements
Module: sample_rgb_pwm

Interface
REQ-001 Parameter: PRESCALE, default 1, clock cycles per PWM step; legal range 1..65535.
REQ-002 The block SHALL have a single clock and a synchronous, active-high reset.
REQ-003 Port: clock  input  1  system clock; all state SHALL update on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: enable  input  1  1 = LEDs driven by PWM; 0 = all LEDs forced off.
REQ-006 Port: duty_valid  input  1  a new duty triple is offered.
REQ-007 Port: duty_ready  output  1  the pending buffer can accept a triple.
REQ-008 Port: duty_red / duty_green / duty_blue  input  8 each  requested on-time in PWM steps out of 256.
REQ-009 Port: period_start  output  1  one-cycle pulse at the start of each PWM period.
REQ-010 Port: led_red_n / led_green_n / led_blue_n  output  1 each  active-low LED drives (0 = lit).

Function
REQ-011 Prescaler: presc_cnt SHALL count 0..PRESCALE-1 and wrap to 0; tick SHALL be 1 in each cycle where presc_cnt == PRESCALE-1 (PRESCALE=1 gives tick every cycle).
REQ-012 PWM counter: pwm_cnt (8 bit) SHALL increment on tick and wrap 255 -> 0; it SHALL NOT stop when enable = 0.
REQ-013 Boundary: a period boundary SHALL occur on any cycle with tick = 1 and pwm_cnt == 255.
REQ-014 period_start SHALL be registered and high for exactly the one cycle after each boundary, i.e. the cycle in which pwm_cnt == 0 is first presented.
REQ-015 Handshake: a transfer SHALL occur when duty_valid & duty_ready; the triple SHALL be captured into the pending registers and pending_full SHALL be set.
REQ-016 duty_ready SHALL equal ~pending_full (registered); duty_ready SHALL NOT combinationally depend on duty_valid.
REQ-017 While duty_valid = 1 and duty_ready = 0, the offered data SHALL be ignored; the source SHALL hold duty_valid and the data stable.
REQ-018 At a boundary with pending_full = 1, the active duties SHALL load from pending and pending_full SHALL clear.
REQ-019 Active duties SHALL change only at boundaries, so no partial period is ever glitched.
REQ-020 Simultaneous transfer and boundary (pending_full = 0): the new triple SHALL go to pending only; active SHALL remain unchanged until the next boundary.
REQ-021 Compare: channel_on SHALL equal enable & (pwm_cnt < active_duty); duty 0 SHALL mean never lit, and duty 255 SHALL mean lit for 255 of 256 steps.
REQ-022 The LED outputs SHALL be registered as led_*_n = ~channel_on, giving a latency of 1 clock from a pwm_cnt/enable change to the pin.
REQ-023 Deasserting enable SHALL turn all LEDs off at the next clock edge, with no effect on the counters, the handshake, or the buffers.
REQ-024 Overall update latency: accepted duty values SHALL appear on the pins between 1 and 257·PRESCALE+1 cycles after the transfer, depending on the phase of the period.

Reset
REQ-025 Reset SHALL set presc_cnt = 0, pwm_cnt = 0, active duties = 0, pending registers = 0, pending_full = 0.
REQ-026 During and after reset, outputs SHALL be: led_*_n = 1, period_start = 0, duty_ready = 1 (from the first cycle after reset).
REQ-027 Reset mid-period SHALL discard both the pending triple and the active triple; the first boundary after reset SHALL occur after 256·PRESCALE cycles.
REQ-028 Reset SHALL override any transfer presented in the same cycle, and that transfer SHALL be dropped.

Verification
REQ-029 Reset then PRESCALE=1, enable=1, no transfer -> led_*_n stays 1 for 1024 cycles; period_start pulses every 256 cycles.
REQ-030 Write (r,g,b)=(64,128,0) -> after the next boundary, per period: red low for exactly 64 cycles, green low for exactly 128 cycles, blue never low; duty_ready returns to 1 the cycle after the boundary.
REQ-031 Write (255,0,255), then hold duty_valid with (1,1,1) -> duty_ready = 0 until the boundary; the second triple is accepted afterwards and applied one boundary later; the sequence of active values is exactly (255,0,255) then (1,1,1).
REQ-032 Transfer on the same cycle as a boundary -> active unchanged for that period; new duty seen in the following period.
REQ-033 enable toggled 1 -> 0 mid-period with red duty 200 -> led_red_n = 1 one cycle later; pwm_cnt continues; re-enable restores the PWM pattern in phase.
REQ-034 PRESCALE=3, duty_red = 2 -> red low for 6 cycles per 768-cycle period; reset asserted mid-period -> all LEDs off and duty_ready = 1 after reset.
